// File: rtl/pc_fetch_pkg.sv
// Shared constants and state encoding for the pc_fetch instruction fetch unit.
// Also provides the helper that drops the low PC bits.
package pc_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0001_0008;

    typedef logic [1:0] state_t;

    localparam state_t ST_FETCH = 2'd0;
    localparam state_t ST_WAIT  = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_HELD  = 2'd3;

    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_skid.sv
// One-entry skid buffer that parks a returned instruction while decode stalls.
// Clear and drain both empty it; load fills it.
module pc_fetch_skid
    import pc_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               drain,
    input  logic               clear,
    input  logic [INSTR_W-1:0] wr_instr,
    input  logic [31:0]        wr_pc,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        pc,
    output logic               full
);

    always_ff @(posedge clk) begin
        if (reset) begin
            full  <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (clear || drain) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            instr <= wr_instr;
            pc    <= wr_pc;
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: one outstanding imem request, IF/ID register, skid.
// Optional macro PC_FETCH_ALIGN_CHECK_EN adds a sticky fetch_misalign output.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        next_pc,
    input  logic               stall,
    input  logic               redirect,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [31:0]        if_pc
`ifdef PC_FETCH_ALIGN_CHECK_EN
    ,
    output logic               fetch_misalign
`endif
);

    state_t state;
    state_t state_nxt;

    logic accept;
    logic pc_load;
    logic deliver_mem;
    logic deliver_skid;
    logic skid_load;
    logic skid_clear;
    logic skid_full;
    logic [INSTR_W-1:0] skid_instr;
    logic [31:0] skid_pc;
    logic [31:0] target;
    logic halt;

`ifdef PC_FETCH_ALIGN_CHECK_EN
    logic bad_target;
    assign target     = next_pc;
    assign bad_target = |next_pc[1:0];
    assign halt       = fetch_misalign;
`else
    logic unused_low;
    assign target     = align_pc(next_pc);
    assign unused_low = ^next_pc[1:0];
    assign halt       = 1'b0;
`endif

    assign imem_req  = (state == ST_FETCH) && !reset && !halt;
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign accept    = imem_req && imem_ready;

    always_comb begin
        state_nxt    = state;
        pc_load      = 1'b0;
        deliver_mem  = 1'b0;
        deliver_skid = 1'b0;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;
        unique case (state)
            ST_FETCH: begin
                pc_load = redirect;
                if (accept) begin
                    state_nxt = redirect ? ST_DRAIN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (redirect) begin
                        pc_load   = 1'b1;
                        state_nxt = ST_FETCH;
                    end else if (stall) begin
                        skid_load = 1'b1;
                        state_nxt = ST_HELD;
                    end else begin
                        deliver_mem = 1'b1;
                        pc_load     = 1'b1;
                        state_nxt   = ST_FETCH;
                    end
                end else if (redirect) begin
                    pc_load   = 1'b1;
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                pc_load = redirect;
                if (imem_rvalid) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_HELD: begin
                if (redirect) begin
                    skid_clear = 1'b1;
                    pc_load    = 1'b1;
                    state_nxt  = ST_FETCH;
                end else if (!stall) begin
                    deliver_skid = 1'b1;
                    pc_load      = 1'b1;
                    state_nxt    = ST_FETCH;
                end
            end
            default: state_nxt = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // A misaligned target never reaches pc; the unit freezes until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (pc_load) begin
`ifdef PC_FETCH_ALIGN_CHECK_EN
            if (!fetch_misalign && !bad_target) begin
                pc <= target;
            end
`else
            pc <= target;
`endif
        end
    end

`ifdef PC_FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_misalign <= 1'b0;
        end else if (pc_load && bad_target) begin
            fetch_misalign <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else if (redirect) begin
            if_valid <= 1'b0;
        end else if (stall) begin
            if_valid <= if_valid;
        end else if (deliver_mem) begin
            if_valid <= 1'b1;
            if_instr <= imem_rdata;
            if_pc    <= pc;
        end else if (deliver_skid) begin
            if_valid <= 1'b1;
            if_instr <= skid_instr;
            if_pc    <= skid_pc;
        end else begin
            if_valid <= 1'b0;
        end
    end

    pc_fetch_skid u_skid (
        .clk      (clk),
        .reset    (reset),
        .load     (skid_load),
        .drain    (deliver_skid),
        .clear    (skid_clear),
        .wr_instr (imem_rdata),
        .wr_pc    (pc),
        .instr    (skid_instr),
        .pc       (skid_pc),
        .full     (skid_full)
    );

    logic unused_full;
    assign unused_full = skid_full;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch with a transaction-level memory and delivery model.
// Memory content is a pure function of address unless a word is injected.
module tb_pc_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] next_pc;
    logic        stall;
    logic        redirect;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
`ifdef PC_FETCH_ALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    logic        sel_p4;
    logic [31:0] np_drv;
    logic        hold_rsp;
    logic        inj_en;
    logic [31:0] inj_data;
    logic        chk_en;
    logic [31:0] last_rsp;
    logic [31:0] q[$];
    logic [31:0] acc_log[$];
    logic [31:0] inj_map[logic [31:0]];
    logic [31:0] sv_instr;
    logic [31:0] sv_pc;
    logic        sv_valid;
    int total;
    int bad;

    assign next_pc = sel_p4 ? pc_plus4 : np_drv;

    pc_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .next_pc     (next_pc),
        .stall       (stall),
        .redirect    (redirect),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc)
`ifdef PC_FETCH_ALIGN_CHECK_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory: accepts when req&ready, answers next cycle unless held.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        @(negedge clk);
        acc = imem_req && imem_ready;
        a   = imem_addr;
        @(posedge clk);
        #1;
        if (acc) begin
            q.push_back(a);
            acc_log.push_back(a);
        end
        imem_rvalid = 1'b0;
        if (!hold_rsp && q.size() > 0) begin
            a = q.pop_front();
            imem_rvalid = 1'b1;
            last_rsp = a;
            if (inj_en) begin
                imem_rdata = inj_data;
                inj_map[a] = inj_data;
                inj_en = 1'b0;
            end else begin
                imem_rdata = memf(a);
            end
        end
    endtask

    // Per-cycle model checks.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("pc_plus4", pc_plus4, pc + 32'd4);
            chk("addr_eq_pc", imem_addr, pc);
            chk("one_outstanding",
                {31'd0, imem_req && (q.size() > 0 || imem_rvalid)}, 32'd0);
            if (if_valid) begin
                chk("if_pc_model", if_pc, last_rsp);
                chk("if_instr_model", if_instr,
                    inj_map.exists(if_pc) ? inj_map[if_pc] : memf(if_pc));
            end
        end
    end

    initial begin
        logic [31:0] exp_addr [3];
        total = 0;
        bad = 0;
        reset = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        imem_ready = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        sel_p4 = 1'b1;
        np_drv = '0;
        hold_rsp = 1'b0;
        inj_en = 1'b0;
        inj_data = '0;
        chk_en = 1'b0;
        last_rsp = '0;
        exp_addr[0] = 32'h0001_0008;
        exp_addr[1] = 32'h0001_000C;
        exp_addr[2] = 32'h0001_0010;

        tick();
        tick();
        chk("rst_pc", pc, 32'h0001_0008);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);

        reset = 1'b0;
        #1;
        chk_en = 1'b1;
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0001_0008);
        tick();
        chk("wait_no_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("lat_valid", {31'd0, if_valid}, 32'd1);
        chk("lat_if_pc", if_pc, 32'h0001_0008);
        chk("lat_next_addr", imem_addr, 32'h0001_000C);
        tick();
        chk("bubble", {31'd0, if_valid}, 32'd0);
        tick();
        chk("i1_pc", if_pc, 32'h0001_000C);
        tick();
        tick();
        chk("i2_pc", if_pc, 32'h0001_0010);
        chk("i2_instr", if_instr, 32'hA5A4_0010);
        chk("acc_cnt", acc_log.size(), 32'd3);
        for (int i = 0; i < 3 && i < acc_log.size(); i++) begin
            chk("acc_seq", acc_log[i], exp_addr[i]);
        end

        inj_en = 1'b1;
        inj_data = 32'h8C01_0004;
        tick();
        stall = 1'b1;
        sv_valid = if_valid;
        sv_instr = if_instr;
        sv_pc = if_pc;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", {31'd0, if_valid}, {31'd0, sv_valid});
            chk("stall_instr", if_instr, sv_instr);
            chk("stall_if_pc", if_pc, sv_pc);
            chk("stall_pc", pc, 32'h0001_0014);
        end
        stall = 1'b0;
        tick();
        chk("skid_valid", {31'd0, if_valid}, 32'd1);
        chk("skid_instr", if_instr, 32'h8C01_0004);
        chk("skid_if_pc", if_pc, 32'h0001_0014);
        chk("skid_pc_once", pc, 32'h0001_0018);

        hold_rsp = 1'b1;
        tick();
        redirect = 1'b1;
        sel_p4 = 1'b0;
        np_drv = 32'h0001_0100;
        tick();
        chk("rd_wait_pc", pc, 32'h0001_0100);
        chk("rd_wait_valid", {31'd0, if_valid}, 32'd0);
        chk("rd_wait_req", {31'd0, imem_req}, 32'd0);
        redirect = 1'b0;
        sel_p4 = 1'b1;
        hold_rsp = 1'b0;
        tick();
        chk("drain_valid", {31'd0, if_valid}, 32'd0);
        tick();
        chk("drain_drop", {31'd0, if_valid}, 32'd0);
        chk("drain_addr", imem_addr, 32'h0001_0100);
        chk("drain_req", {31'd0, imem_req}, 32'd1);

        tick();
        redirect = 1'b1;
        sel_p4 = 1'b0;
        np_drv = 32'h0001_0200;
        tick();
        chk("rdv_valid", {31'd0, if_valid}, 32'd0);
        chk("rdv_addr", imem_addr, 32'h0001_0200);
        chk("rdv_req", {31'd0, imem_req}, 32'd1);
        redirect = 1'b0;
        sel_p4 = 1'b1;

        imem_ready = 1'b0;
        redirect = 1'b1;
        sel_p4 = 1'b0;
        np_drv = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        sel_p4 = 1'b1;
        imem_ready = 1'b1;
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_p4", pc_plus4, 32'h0000_0000);
        tick();
        tick();
        chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        chk("wrap_valid", {31'd0, if_valid}, 32'd1);

        imem_ready = 1'b0;
        redirect = 1'b1;
        sel_p4 = 1'b0;
        np_drv = 32'h0001_0102;
        tick();
        redirect = 1'b0;
        sel_p4 = 1'b1;
        imem_ready = 1'b1;
`ifdef PC_FETCH_ALIGN_CHECK_EN
        tick();
        tick();
        chk("mis_flag", {31'd0, fetch_misalign}, 32'd1);
        chk("mis_pc", pc, 32'h0000_0000);
        chk("mis_req", {31'd0, imem_req}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mis_clr", {31'd0, fetch_misalign}, 32'd0);
        chk("mis_clr_req", {31'd0, imem_req}, 32'd1);
`else
        chk("low_bits_ignored", pc, 32'h0001_0100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
`endif
        chk("rst2_pc", pc, 32'h0001_0008);

        hold_rsp = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_en = 1'b0;
        imem_ready = 1'b0;
        hold_rsp = 1'b0;
        tick();
        tick();
        chk("stale_valid", {31'd0, if_valid}, 32'd0);
        chk("stale_pc", pc, 32'h0001_0008);
        chk("stale_req", {31'd0, imem_req}, 32'd1);
        chk_en = 1'b1;
        imem_ready = 1'b1;
        tick();
        tick();
        chk("post_rst_valid", {31'd0, if_valid}, 32'd1);
        chk("post_rst_if_pc", if_pc, 32'h0001_0008);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0001_0008, PC value loaded on reset.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 next_pc  input  32  next PC from the external PC-select mux.
REQ-005 stall  input  1  decode stall; hold IF/ID outputs.
REQ-006 redirect  input  1  branch/jump taken; flush and load next_pc.
REQ-007 imem_req  output  1  instruction memory request valid.
REQ-008 imem_addr  output  32  request address, equals pc.
REQ-009 imem_ready  input  1  request accepted this cycle when imem_req=1.
REQ-010 imem_rvalid  input  1  read data valid; one response per accepted request, in order.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 pc  output  32  current fetch PC.
REQ-013 pc_plus4  output  32  pc+4, combinational, drives mux in1.
REQ-014 if_valid, if_instr, if_pc  output  1/32/32  registered IF/ID outputs.

Function
REQ-015 The FSM SHALL have four states: FETCH, WAIT, DRAIN, HELD. At most one request is outstanding.
REQ-016 FETCH: imem_req=1, imem_addr=pc. On imem_ready -> WAIT, or -> DRAIN if redirect is also high. On redirect: pc<=next_pc.
REQ-017 WAIT: imem_req=0. Three cases apply on imem_rvalid:
- redirect: drop the data, pc<=next_pc, -> FETCH.
- stall: store the data and pc in the skid entry, -> HELD.
- neither: if_valid<=1, if_instr<=imem_rdata, if_pc<=pc, pc<=next_pc, -> FETCH.
REQ-018 WAIT with redirect and no rvalid: pc<=next_pc, -> DRAIN.
REQ-019 DRAIN: wait for rvalid, discard it, -> FETCH. A redirect in DRAIN reloads pc<=next_pc.
REQ-020 HELD: stays in HELD while stall=1.
- When stall=0: if_* load from skid, pc<=next_pc, -> FETCH.
- On redirect: skid discarded, pc<=next_pc, -> FETCH.
REQ-021 IF/ID priority: redirect clears if_valid (flush) over everything. Otherwise stall holds if_* unchanged. Otherwise, with no new instruction, if_valid<=0 (bubble) and if_instr/if_pc hold.
REQ-022 pc_plus4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-023 Latency: request to if_valid is minimum 2 cycles when imem_ready and rvalid each arrive in the cycle following the state entry.
REQ-024 The next request is issued in the cycle after delivery. Fetch throughput is therefore 1 instruction per 2 cycles at best.

Reset
REQ-025 While reset=1:
- pc=RESET_PC, state=FETCH, skid empty.
- if_valid=0, if_instr=0, if_pc=0.
- imem_req=0.
REQ-026 A reset mid-transaction abandons the outstanding request. rvalid arriving after reset SHALL be ignored until a new request is accepted.

Configuration
REQ-027 Macro PC_FETCH_ALIGN_CHECK_EN.
- Defined: adds output fetch_misalign (1 bit), set sticky when a pc update sees next_pc[1:0]!=0. That update is suppressed (pc holds) and imem_req is forced to 0 until reset.
- Undefined: the port is absent and next_pc[1:0] is treated as 2'b00.

Structure
REQ-028 Package pc_fetch_pkg SHALL hold the state enum, the default RESET_PC constant 32'h0001_0008 and the INSTR_W=32 constant.
REQ-029 Sub-module pc_fetch_skid SHALL hold the one-entry {instr, pc, full} skid buffer with load/drain/clear controls.

Verification
REQ-030 Reset release, ready=1 and rvalid one cycle after acceptance, stall=0, next_pc=pc_plus4:
- imem_addr sequence is 0x10008, 0x1000C, 0x10010.
- if_valid pulses carry matching if_pc.
REQ-031 rvalid arrives with stall=1 (instr 0x8C010004), stall held 3 cycles:
- if_* stay unchanged during the stall.
- One cycle after stall drops: if_instr=0x8C010004, pc advances exactly once.
REQ-032 redirect=1 with next_pc=0x10100 while in WAIT, no rvalid:
- The following rvalid data is discarded and if_valid=0.
- Next imem_addr=0x10100.
REQ-033 Simultaneous redirect and rvalid in WAIT: data dropped, if_valid=0 next cycle, FETCH at next_pc.
REQ-034 pc=32'hFFFF_FFFC: pc_plus4=0; after delivery with next_pc=pc_plus4, imem_addr=0.
REQ-035 With PC_FETCH_ALIGN_CHECK_EN, redirect with next_pc=0x10102:
- fetch_misalign=1 and stays high; pc unchanged; imem_req=0.
- All of the above clear on reset.
